qinj_fanout_seq: RTL and testbench

- Synthesizable, parametrised successor to the pixel-matrix charge-injection fan-out.
- On a charge-injection trigger from the fast-command path, it waits a programmable delay. It then drives per-pixel injection pulses of programmable width.
- Pulses go out group by group with a programmable stagger, modelling and controlling tree skew across the matrix.
- Sits between the fast-command decoder and the pixel array; per-pixel enable mask.

---
 rtl/qinj_fanout_seq.sv | 155 +++++++++++++++
 tb/tb_qinj_fanout_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/qinj_fanout_seq.sv
// qinj_fanout_seq: charge-injection fan-out sequencer.
// A fast-command trigger starts a programmable delay. The per-pixel
// injection pulses then go out group by group, with a programmable width
// and a programmable stagger between group start times.
module qinj_fanout_seq #(
  parameter int N_PIX   = 256,
  parameter int N_GROUP = 16,
  parameter int DLY_W   = 5,
  parameter int PW_W    = 4,
  parameter int STG_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             qinj_trig,
  input  logic [DLY_W-1:0] delay_cfg,
  input  logic [PW_W-1:0]  width_cfg,
  input  logic [STG_W-1:0] stagger_cfg,
  input  logic [N_PIX-1:0] pix_en,
  output logic [N_PIX-1:0] qinj_out,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic [CNT_W-1:0] pulse_cnt,
  input  logic             clr_stat
);

  localparam int GRP_SZ = N_PIX / N_GROUP;
  // Time base wide enough for the longest sequence plus one spare bit, so t never wraps.
  localparam int T_W    = $clog2((N_GROUP - 1) * (2**STG_W - 1) + 2**PW_W) + 1;

  typedef enum logic [1:0] {IDLE, DELAY, FIRE, DONE} state_e;

  state_e             state_q;
  logic [DLY_W-1:0]   cnt_q;
  logic [T_W-1:0]     t_q;
  logic [T_W-1:0]     t_last;
  logic [PW_W-1:0]    w_q;
  logic [STG_W-1:0]   s_q;
  logic [N_PIX-1:0]   en_q;
  logic [N_PIX-1:0]   out_q;
  logic [N_PIX-1:0]   fire_d;
  logic               busy_q;
  logic               done_q;
  logic               overrun_q;
  logic [CNT_W-1:0]   pulse_cnt_q;
  logic               trig_acc;

  // Group g is active while g*S <= t < g*S + W.
  function automatic logic grp_on(input logic [T_W-1:0]   g,
                                  input logic [T_W-1:0]   t,
                                  input logic [STG_W-1:0] s,
                                  input logic [PW_W-1:0]  w);
    logic [T_W-1:0] st;
    st = g * T_W'(s);
    return (t >= st) && (t < st + T_W'(w));
  endfunction

  assign trig_acc = qinj_trig && (state_q == IDLE);

  // Last time step of the sequence: (N_GROUP-1)*S + W - 1.
  assign t_last = T_W'(N_GROUP - 1) * T_W'(s_q) + T_W'(w_q) - T_W'(1);

  // Latch the configuration when a trigger is accepted; the running sequence uses only these copies.
  always_ff @(posedge clk) begin
    if (trig_acc) begin
      w_q  <= (width_cfg == '0) ? PW_W'(1) : width_cfg;
      s_q  <= stagger_cfg;
      en_q <= pix_en;
    end
  end

  // Next pulse pattern for the current time step, masked by the latched enables.
  always_comb begin
    fire_d = '0;
    for (int g = 0; g < N_GROUP; g++) begin
      if (grp_on(T_W'(g), t_q, s_q, w_q)) begin
        fire_d[g*GRP_SZ +: GRP_SZ] = en_q[g*GRP_SZ +: GRP_SZ];
      end
    end
  end

  // Sequencer FSM with registered pulse, busy and done outputs.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      out_q  <= '0;
      case (state_q)
        IDLE: begin
          if (qinj_trig) begin
            busy_q  <= 1'b1;
            t_q     <= '0;
            cnt_q   <= delay_cfg;
            state_q <= (delay_cfg == '0) ? FIRE : DELAY;
          end
        end
        DELAY: begin
          // Leaving on count 1 keeps group 0's first high cycle at trigger edge + 1 + D.
          if (cnt_q == DLY_W'(1)) begin
            state_q <= FIRE;
            t_q     <= '0;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        FIRE: begin
          out_q <= fire_d;
          t_q   <= t_q + T_W'(1);
          if (t_q == t_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky overrun flag and saturating sequence counter; a clear takes priority over any update.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      overrun_q   <= 1'b0;
      pulse_cnt_q <= '0;
    end else begin
      if (clr_stat) begin
        overrun_q <= 1'b0;
      end else if (qinj_trig && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (clr_stat) begin
        pulse_cnt_q <= '0;
      end else if ((state_q == DONE) && (pulse_cnt_q != '1)) begin
        pulse_cnt_q <= pulse_cnt_q + CNT_W'(1);
      end
    end
  end

  assign qinj_out  = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_qinj_fanout_seq.sv
// Directed bench for qinj_fanout_seq: timing, stagger, masking, overrun,
// asynchronous reset and counter saturation.
module tb_qinj_fanout_seq;

  localparam int N_PIX   = 256;
  localparam int N_GROUP = 16;
  localparam int DLY_W   = 5;
  localparam int PW_W    = 4;
  localparam int STG_W   = 3;
  localparam int CNT_W   = 16;

  logic             clk = 1'b0;
  logic             RSTn;
  logic             qinj_trig;
  logic [DLY_W-1:0] delay_cfg;
  logic [PW_W-1:0]  width_cfg;
  logic [STG_W-1:0] stagger_cfg;
  logic [N_PIX-1:0] pix_en;
  logic [N_PIX-1:0] qinj_out;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [CNT_W-1:0] pulse_cnt;
  logic             clr_stat;

  // Small instance used for counter saturation: 16 pixels, 4 groups, 4-bit counter.
  logic             trig2;
  logic [15:0]      pix_en2;
  logic [15:0]      out2;
  logic             busy2;
  logic             done2;
  logic             overrun2;
  logic [3:0]       cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [255:0] exp_v;

  always #5 clk = ~clk;

  qinj_fanout_seq #(
    .N_PIX(N_PIX), .N_GROUP(N_GROUP), .DLY_W(DLY_W),
    .PW_W(PW_W), .STG_W(STG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .RSTn(RSTn), .qinj_trig(qinj_trig), .delay_cfg(delay_cfg),
    .width_cfg(width_cfg), .stagger_cfg(stagger_cfg), .pix_en(pix_en),
    .qinj_out(qinj_out), .busy(busy), .done(done), .overrun(overrun),
    .pulse_cnt(pulse_cnt), .clr_stat(clr_stat)
  );

  qinj_fanout_seq #(
    .N_PIX(16), .N_GROUP(4), .DLY_W(DLY_W),
    .PW_W(PW_W), .STG_W(STG_W), .CNT_W(4)
  ) dut_sat (
    .clk(clk), .RSTn(RSTn), .qinj_trig(trig2), .delay_cfg(delay_cfg),
    .width_cfg(width_cfg), .stagger_cfg(stagger_cfg), .pix_en(pix_en2),
    .qinj_out(out2), .busy(busy2), .done(done2), .overrun(overrun2),
    .pulse_cnt(cnt2), .clr_stat(clr_stat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pixels of group g (16 pixels per group), empty for an out-of-range group.
  function automatic logic [255:0] gmask(input int g);
    logic [255:0] m;
    m = 256'hFFFF;
    if (g < 0 || g >= N_GROUP) return '0;
    return m << (g * 16);
  endfunction

  initial begin
    RSTn = 1'b0; qinj_trig = 1'b0; clr_stat = 1'b0;
    delay_cfg = '0; width_cfg = '0; stagger_cfg = '0; pix_en = '0;
    trig2 = 1'b0; pix_en2 = '0;
    tick(); tick();
    chk("rst_out",     256'(qinj_out),  '0);
    chk("rst_busy",    256'(busy),      '0);
    chk("rst_done",    256'(done),      '0);
    chk("rst_overrun", 256'(overrun),   '0);
    chk("rst_cnt",     256'(pulse_cnt), '0);
    RSTn = 1'b1;
    tick();

    // 1: D=3 W=2 S=0, all pixels: high after edges k+4 and k+5, done at k+6.
    delay_cfg = 5'd3; width_cfg = 4'd2; stagger_cfg = 3'd0; pix_en = {N_PIX{1'b1}};
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    chk("t1_busy_k", 256'(busy), 256'(1));
    chk("t1_out_k", qinj_out, '0);
    for (int j = 1; j <= 6; j++) begin
      tick();
      exp_v = (j == 4 || j == 5) ? {256{1'b1}} : 256'(0);
      chk("t1_out", qinj_out, exp_v);
      chk("t1_done", 256'(done), 256'(j == 6));
    end
    chk("t1_busy_end", 256'(busy), '0);
    chk("t1_cnt", 256'(pulse_cnt), 256'(1));
    tick();
    chk("t1_done_1cyc", 256'(done), '0);

    // 2: D=0 W=0(->1) S=1: one group per cycle, groups 0..15 at k+1..k+16.
    delay_cfg = 5'd0; width_cfg = 4'd0; stagger_cfg = 3'd1;
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    chk("t2_busy_k", 256'(busy), 256'(1));
    for (int j = 1; j <= 17; j++) begin
      tick();
      exp_v = (j <= 16) ? gmask(j - 1) : 256'(0);
      chk("t2_out", qinj_out, exp_v);
      chk("t2_busy", 256'(busy), 256'(j <= 16));
      chk("t2_done", 256'(done), 256'(j == 17));
    end
    chk("t2_cnt", 256'(pulse_cnt), 256'(2));

    // 3: only pixels 0 and 255, D=2 W=4 S=2.
    pix_en = '0; pix_en[0] = 1'b1; pix_en[255] = 1'b1;
    delay_cfg = 5'd2; width_cfg = 4'd4; stagger_cfg = 3'd2;
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    for (int j = 1; j <= 37; j++) begin
      tick();
      exp_v = '0;
      if (j >= 3 && j <= 6)   exp_v[0]   = 1'b1;
      if (j >= 33 && j <= 36) exp_v[255] = 1'b1;
      chk("t3_out", qinj_out, exp_v);
      chk("t3_done", 256'(done), 256'(j == 37));
    end
    chk("t3_cnt", 256'(pulse_cnt), 256'(3));

    // 4: D=3 W=2 S=1; retrigger in DELAY (with new config) and in FIRE.
    pix_en = {N_PIX{1'b1}}; delay_cfg = 5'd3; width_cfg = 4'd2; stagger_cfg = 3'd1;
    chk("t4_ovr_before", 256'(overrun), '0);
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      if (j == 1) begin
        qinj_trig = 1'b1; delay_cfg = 5'd0; width_cfg = 4'd7; stagger_cfg = 3'd0; pix_en = '0;
      end else begin
        qinj_trig = (j == 6);
      end
      tick();
      exp_v = '0;
      if (j >= 4 && j <= 20) exp_v = gmask(j - 4) | gmask(j - 5);
      chk("t4_out", qinj_out, exp_v);
      chk("t4_done", 256'(done), 256'(j == 21));
    end
    qinj_trig = 1'b0;
    chk("t4_cnt", 256'(pulse_cnt), 256'(4));
    chk("t4_ovr", 256'(overrun), 256'(1));
    clr_stat = 1'b1; tick(); clr_stat = 1'b0;
    chk("t4_ovr_clr", 256'(overrun), '0);
    chk("t4_cnt_clr", 256'(pulse_cnt), '0);

    // 5: D=5 W=3 S=1; trigger+clear in DELAY, then async reset mid-FIRE.
    pix_en = {N_PIX{1'b1}}; delay_cfg = 5'd5; width_cfg = 4'd3; stagger_cfg = 3'd1;
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    tick();
    qinj_trig = 1'b1; clr_stat = 1'b1; tick(); qinj_trig = 1'b0; clr_stat = 1'b0;
    chk("t5_ovr_clrwin", 256'(overrun), '0);
    for (int j = 3; j <= 7; j++) tick();
    chk("t5_out_fire", qinj_out, gmask(0) | gmask(1));
    chk("t5_busy_fire", 256'(busy), 256'(1));
    #3 RSTn = 1'b0;
    #1;
    chk("t5_out_async", qinj_out, '0);
    chk("t5_busy_async", 256'(busy), '0);
    tick(); tick();
    chk("t5_done_rst", 256'(done), '0);
    chk("t5_cnt_rst", 256'(pulse_cnt), '0);
    RSTn = 1'b1;
    tick();
    delay_cfg = 5'd1; width_cfg = 4'd1; stagger_cfg = 3'd0;
    qinj_trig = 1'b1; tick(); qinj_trig = 1'b0;
    chk("t5_busy_re", 256'(busy), 256'(1));
    tick();
    chk("t5_out_re1", qinj_out, '0);
    tick();
    chk("t5_out_re2", qinj_out, {256{1'b1}});
    tick();
    chk("t5_out_re3", qinj_out, '0);
    chk("t5_done_re", 256'(done), 256'(1));
    chk("t5_cnt_re", 256'(pulse_cnt), 256'(1));

    // 6: back-to-back D=0 W=1 S=0 on the 4-bit-counter instance, retrigger in each done cycle.
    delay_cfg = 5'd0; width_cfg = 4'd1; stagger_cfg = 3'd0;
    for (int n = 1; n <= 16; n++) begin
      pix_en2 = (n == 1) ? 16'h0000 : (16'hA5C3 ^ 16'(n));
      trig2 = 1'b1; tick(); trig2 = 1'b0;
      chk("t6_busy", 256'(busy2), 256'(1));
      tick();
      chk("t6_out", 256'(out2), 256'(pix_en2));
      tick();
      chk("t6_done", 256'(done2), 256'(1));
      chk("t6_cnt", 256'(cnt2), 256'((n < 15) ? n : 15));
    end
    chk("t6_ovr", 256'(overrun2), '0);
    tick();
    chk("t6_done_end", 256'(done2), '0);
    chk("t6_cnt_hold", 256'(cnt2), 256'(15));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
